// File: rtl/timer_sched_pkg.sv
// Shared encodings for the timer scheduler: command opcodes and the
// channel / interrupt state types.
package timer_sched_pkg;

   localparam logic OP_LOAD_START = 1'b0;
   localparam logic OP_STOP       = 1'b1;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

   typedef enum logic {
      I_IDLE   = 1'b0,
      I_ASSERT = 1'b1
   } irq_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the input clock down to a one-cycle time-base tick that fires on the
// last count of each DEF_FREQ/TICK_HZ cycle window.
module tick_prescaler #(
   parameter int DEF_FREQ = 27000000,
   parameter int TICK_HZ  = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int DIV = DEF_FREQ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (r_cnt == PW'(DIV - 1))
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + PW'(1);
   end

   assign tick = (r_cnt == PW'(DIV - 1));

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel tick-based timer with one-shot / auto-reload channels and a
// single prioritised interrupt. Define TIMER_SCHED_OVERRUN_EN for overrun flags.
module timer_scheduler
   import timer_sched_pkg::*;
#(
   parameter int DEF_FREQ = 27000000,
   parameter int TICK_HZ  = 1000,
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_op,
   input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
   input  logic [CNT_W-1:0]          cmd_period,
   input  logic                      cmd_periodic,
   output logic                      cmd_err,
   output logic                      tick,
   output logic [NUM_CH-1:0]         ch_busy,
   output logic                      irq,
   output logic [$clog2(NUM_CH)-1:0] irq_ch,
   input  logic                      irq_ack,
   output logic                      irq_overrun
);
   localparam int CH_W = $clog2(NUM_CH);

   logic              w_tick;
   logic              w_acc;
   logic              w_bad;
   logic              w_ack;
   logic [NUM_CH-1:0] w_exp;
   logic [NUM_CH-1:0] w_ack_ch;
   logic [CH_W-1:0]   w_low;

   ch_state_e         r_st  [NUM_CH];
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   logic [CNT_W-1:0]  r_per [NUM_CH];
   logic [NUM_CH-1:0] r_mode;
   logic [NUM_CH-1:0] r_pend;
   logic              r_err;
   irq_state_e        r_ist;
   logic [CH_W-1:0]   r_irq_ch;

   tick_prescaler #(
      .DEF_FREQ (DEF_FREQ),
      .TICK_HZ  (TICK_HZ)
   ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Commands are refused in tick cycles, so a command never collides with a
   // count update on the same edge.
   assign cmd_ready = !rst && !w_tick;

   always_comb begin
      w_acc = cmd_valid && cmd_ready;
      w_bad = (int'(cmd_ch) >= NUM_CH) ||
              ((cmd_op == OP_LOAD_START) && (cmd_period == '0));
      w_ack = (r_ist == I_ASSERT) && irq_ack;
      w_low = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (r_pend[i]) w_low = CH_W'(i);
      for (int i = 0; i < NUM_CH; i++) begin
         w_exp[i]    = w_tick && (r_st[i] == CH_RUN) && (r_cnt[i] == CNT_W'(1));
         w_ack_ch[i] = w_ack && (r_irq_ch == CH_W'(i));
         ch_busy[i]  = (r_st[i] == CH_RUN);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err  <= 1'b0;
         r_mode <= '0;
         r_pend <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_st[i]  <= CH_IDLE;
            r_cnt[i] <= '0;
            r_per[i] <= '0;
         end
      end else begin
         r_err <= w_acc && w_bad;
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_acc && !w_bad && (cmd_ch == CH_W'(i))) begin
               if (cmd_op == OP_LOAD_START) begin
                  r_st[i]   <= CH_RUN;
                  r_cnt[i]  <= cmd_period;
                  r_per[i]  <= cmd_period;
                  r_mode[i] <= cmd_periodic;
               end else begin
                  r_st[i] <= CH_IDLE;
               end
            end else if (w_tick && (r_st[i] == CH_RUN)) begin
               if (r_cnt[i] == CNT_W'(1)) begin
                  if (r_mode[i]) r_cnt[i] <= r_per[i];
                  else           r_st[i]  <= CH_IDLE;
               end else begin
                  r_cnt[i] <= r_cnt[i] - CNT_W'(1);
               end
            end
            // A fresh expiry wins over an ack landing on the same channel.
            if (w_exp[i])         r_pend[i] <= 1'b1;
            else if (w_ack_ch[i]) r_pend[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ist    <= I_IDLE;
         r_irq_ch <= '0;
      end else begin
         case (r_ist)
            I_IDLE: begin
               if (|r_pend) begin
                  r_irq_ch <= w_low;
                  r_ist    <= I_ASSERT;
               end
            end
            I_ASSERT: begin
               if (irq_ack) r_ist <= I_IDLE;
            end
            default: r_ist <= I_IDLE;
         endcase
      end
   end

   assign cmd_err = r_err;
   assign tick    = w_tick;
   assign irq     = (r_ist == I_ASSERT);
   assign irq_ch  = r_irq_ch;

`ifdef TIMER_SCHED_OVERRUN_EN
   logic [NUM_CH-1:0] r_ovr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovr <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_exp[i] && r_pend[i] && !w_ack_ch[i]) r_ovr[i] <= 1'b1;
            else if (w_ack_ch[i])                      r_ovr[i] <= 1'b0;
         end
      end
   end

   assign irq_overrun = irq && r_ovr[r_irq_ch];
`else
   assign irq_overrun = 1'b0;
`endif

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter DEF_FREQ, default 27000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, time-base tick rate in Hz; DEF_FREQ/TICK_HZ SHALL be an integer >= 2.
REQ-003 SHALL have parameter NUM_CH, default 4, number of timer channels (2..8).
REQ-004 SHALL have parameter CNT_W, default 16, channel period width.
REQ-005 Ports, one per line: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command present; cmd_ready  out  1  command accepted when both high.
REQ-007 cmd_op  in  1  0=LOAD_START, 1=STOP; cmd_ch  in  $clog2(NUM_CH)  target channel.
REQ-008 cmd_period  in  CNT_W  period in ticks; cmd_periodic  in  1  1=auto-reload, 0=one-shot.
REQ-009 cmd_err  out  1  one-cycle pulse, rejected command; tick  out  1  one-cycle time-base pulse.
REQ-010 ch_busy  out  NUM_CH  channel running; irq  out  1  interrupt request; irq_ch  out  $clog2(NUM_CH)  source channel.
REQ-011 irq_ack  in  1  interrupt acknowledge; irq_overrun  out  1  source channel lost at least one expiry.

Function
REQ-012 Prescaler SHALL count 0..DEF_FREQ/TICK_HZ-1 and wrap; tick SHALL be high exactly in the cycle the count equals terminal.
REQ-013 cmd_ready SHALL be 0 in tick cycles, 1 otherwise; accepted commands take effect the following cycle.
REQ-014 LOAD_START with cmd_period=0, or cmd_ch>=NUM_CH, SHALL be rejected: channel unchanged, cmd_err pulsed next cycle.
REQ-015 Per-channel states IDLE and RUN; LOAD_START loads count=cmd_period, latches mode, enters RUN (restarts if already RUN).
REQ-016 STOP SHALL force IDLE; STOP on IDLE channel SHALL have no effect; STOP SHALL NOT clear a pending expiry.
REQ-017 On tick in RUN: count==1 is an expiry, else count decrements.
REQ-018 On expiry: pending bit set; periodic reloads latched period and stays RUN; one-shot goes IDLE.
REQ-019 ch_busy[i] SHALL equal (state==RUN).
REQ-020 Interrupt FSM states I_IDLE, I_ASSERT; in I_IDLE with any pending bit, SHALL latch lowest-index pending channel into irq_ch and enter I_ASSERT.
REQ-021 irq SHALL equal (state==I_ASSERT); irq_ch SHALL remain stable while irq high.
REQ-022 irq_ack in I_ASSERT SHALL clear pending[irq_ch] and return to I_IDLE (minimum one cycle irq low between interrupts); irq_ack in I_IDLE ignored.
REQ-023 Expiry on irq_ch in the same cycle as irq_ack SHALL leave pending set (new event) and SHALL NOT count as overrun.
REQ-024 Expiry on a channel whose pending bit is already set SHALL set that channel's sticky overrun bit.

Reset
REQ-025 rst high SHALL asynchronously clear prescaler, all counts, pending and overrun bits; channels IDLE, FSM I_IDLE.
REQ-026 During reset: tick=0, cmd_err=0, irq=0, irq_ch=0, ch_busy=0, irq_overrun=0, cmd_ready=0; cmd_ready=1 from first cycle after release unless tick.
REQ-027 Reset mid-operation SHALL discard pending commands and interrupts without a completing ack.

Configuration
REQ-028 With TIMER_SCHED_OVERRUN_EN defined: irq_overrun SHALL equal overrun[irq_ch] while irq high, else 0; ack clears overrun[irq_ch] with pending.
REQ-029 Without TIMER_SCHED_OVERRUN_EN: overrun bits not implemented, irq_overrun tied 0; all other behaviour identical.

Structure
REQ-030 Package timer_sched_pkg SHALL hold op encodings (OP_LOAD_START, OP_STOP), channel and interrupt state enums.
REQ-031 Prescaler SHALL be a sub-module tick_prescaler (params DEF_FREQ, TICK_HZ; ports clk, rst, tick).

Verification (DEF_FREQ=100, TICK_HZ=10, so tick every 10 cycles)
REQ-032 Reset release -> tick first at cycle 10, then every 10 cycles; cmd_ready low only in tick cycles.
REQ-033 LOAD_START ch1, period 3, one-shot -> irq high, irq_ch=1 after 3rd tick; ch_busy[1]=0; ack -> irq low next cycle.
REQ-034 ch0 and ch2 periodic period 2, same start -> both expire same tick; irq_ch=0 first, after ack irq_ch=2.
REQ-035 ch3 periodic period 1, no ack for 2 ticks -> irq_overrun=1 with macro, 0 without; ack clears it.
REQ-036 LOAD_START period 0 -> cmd_err pulse, channel state unchanged; STOP on idle ch2 -> no change.
REQ-037 rst asserted while irq high and ch1 running -> irq, ch_busy, tick go 0 immediately, no interrupt after release.
